// File: rtl/voice_scheduler.sv
// Frame-synchronous sequencer for the per-voice ADSR pipeline: sweeps every voice through
// read / compute / key-update slots once per frame and issues buffered note events in slot 0.
module voice_scheduler #(
  parameter int NUM_VOICES     = 128,
  parameter int CLKS_PER_FRAME = 1024,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic       i_note_valid,
  input  logic       i_note_status,
  input  logic [7:0] i_note_voice,
  output logic       o_note_ready,
  output logic       o_overflow,
  input  logic       i_clear_overflow,
  output logic [7:0] o_voice_index,
  output logic [1:0] o_pipeline_state,
  output logic       o_upd_flag,
  output logic       o_upd_note_status,
  output logic [7:0] o_upd_voice_index,
  output logic       o_frame_start,
  output logic       o_frame_done
);

  localparam int CW = $clog2(CLKS_PER_FRAME);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam logic [CW-1:0] LAST_CNT   = CW'(CLKS_PER_FRAME - 1);
  localparam logic [7:0]    LAST_VOICE = 8'(NUM_VOICES - 1);
  localparam logic [NW-1:0] FULL_CNT   = NW'(FIFO_DEPTH);

  if (NUM_VOICES < 1 || NUM_VOICES > 256) begin : g_bad_voices
    $error("voice_scheduler: NUM_VOICES must be 1..256");
  end
  if (CLKS_PER_FRAME < 3 * NUM_VOICES + 1) begin : g_bad_frame
    $error("voice_scheduler: CLKS_PER_FRAME must be >= 3*NUM_VOICES+1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("voice_scheduler: FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [1:0] {
    ST_S0   = 2'd0,
    ST_S1   = 2'd1,
    ST_S2   = 2'd2,
    ST_IDLE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      voice_q, voice_d;
  logic            running_q, running_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_done_q, frame_done_d;
  logic            upd_flag_q, upd_flag_d;
  logic            upd_status_q, upd_status_d;
  logic [7:0]      upd_voice_q, upd_voice_d;
  logic            ready_q, ready_d;
  logic            overflow_q, overflow_d;
  logic [NW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [8:0]      mem_q [FIFO_DEPTH];
  logic            boundary, start, push, pop;

  // Enable is only looked at when idle or on the last clock of a running frame.
  assign boundary = !running_q || (cnt_q == LAST_CNT);
  assign start    = boundary && i_enable;
  // Ready is registered, so a write that lands while full is dropped even if a pop is in flight.
  assign push     = i_note_valid && ready_q;
  assign pop      = upd_flag_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      voice_q       <= '0;
      running_q     <= 1'b0;
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      upd_flag_q    <= 1'b0;
      upd_status_q  <= 1'b0;
      upd_voice_q   <= '0;
      ready_q       <= 1'b1;
      overflow_q    <= 1'b0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      voice_q       <= voice_d;
      running_q     <= running_d;
      cnt_q         <= cnt_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      upd_flag_q    <= upd_flag_d;
      upd_status_q  <= upd_status_d;
      upd_voice_q   <= upd_voice_d;
      ready_q       <= ready_d;
      overflow_q    <= overflow_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {i_note_status, i_note_voice};
    end
  end

  always_comb begin
    state_d = state_q;
    voice_d = voice_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_S0;
          voice_d = '0;
        end
      end
      ST_S0: state_d = ST_S1;
      ST_S1: state_d = ST_S2;
      ST_S2: begin
        if (voice_q == LAST_VOICE) begin
          state_d = ST_IDLE;
          voice_d = '0;
        end else begin
          state_d = ST_S0;
          voice_d = voice_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_start_d = start;
    frame_done_d  = (state_q == ST_S2) && (voice_q == LAST_VOICE);
    upd_flag_d    = (state_d == ST_S0) && (count_q != '0);
    upd_status_d  = upd_status_q;
    upd_voice_d   = upd_voice_q;
    if (upd_flag_d) begin
      upd_status_d = mem_q[rd_ptr_q][8];
      upd_voice_d  = mem_q[rd_ptr_q][7:0];
    end
  end

  always_comb begin
    if (boundary) begin
      running_d = i_enable;
      cnt_d     = '0;
    end else begin
      running_d = 1'b1;
      cnt_d     = cnt_q + CW'(1);
    end
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != FULL_CNT);
    if (i_note_valid && !ready_q) begin
      overflow_d = 1'b1;
    end else if (i_clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  assign o_note_ready      = ready_q;
  assign o_overflow        = overflow_q;
  assign o_voice_index     = voice_q;
  assign o_pipeline_state  = state_q;
  assign o_upd_flag        = upd_flag_q;
  assign o_upd_note_status = upd_status_q;
  assign o_upd_voice_index = upd_voice_q;
  assign o_frame_start     = frame_start_q;
  assign o_frame_done      = frame_done_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Randomized bench for voice_scheduler: a frame-timeline reference model with a note-event queue
// predicts every registered output each cycle; async resets are injected mid-frame.
module tb_voice_scheduler;

  localparam int NV    = 4;
  localparam int CLKS  = 16;
  localparam int DEPTH = 2;
  localparam int NCYC  = 4000;

  logic       clk = 1'b0;
  logic       i_reset_n;
  logic       i_enable;
  logic       i_note_valid;
  logic       i_note_status;
  logic [7:0] i_note_voice;
  logic       i_clear_overflow;
  logic       o_note_ready;
  logic       o_overflow;
  logic [7:0] o_voice_index;
  logic [1:0] o_pipeline_state;
  logic       o_upd_flag;
  logic       o_upd_note_status;
  logic [7:0] o_upd_voice_index;
  logic       o_frame_start;
  logic       o_frame_done;

  always #5 clk = ~clk;

  voice_scheduler #(
    .NUM_VOICES     (NV),
    .CLKS_PER_FRAME (CLKS),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .i_clk             (clk),
    .i_reset_n         (i_reset_n),
    .i_enable          (i_enable),
    .i_note_valid      (i_note_valid),
    .i_note_status     (i_note_status),
    .i_note_voice      (i_note_voice),
    .o_note_ready      (o_note_ready),
    .o_overflow        (o_overflow),
    .i_clear_overflow  (i_clear_overflow),
    .o_voice_index     (o_voice_index),
    .o_pipeline_state  (o_pipeline_state),
    .o_upd_flag        (o_upd_flag),
    .o_upd_note_status (o_upd_note_status),
    .o_upd_voice_index (o_upd_voice_index),
    .o_frame_start     (o_frame_start),
    .o_frame_done      (o_frame_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: frame position, pending events, and predicted outputs.
  logic [8:0] exp_q[$];
  bit running;
  int fpos;
  bit pend_pop;
  bit m_ovf;
  int e_state, e_voice;
  bit e_flag, e_st, e_start, e_done, e_ready;
  int e_vi;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    running  = 1'b0;
    fpos     = 0;
    pend_pop = 1'b0;
    m_ovf    = 1'b0;
    e_state  = 3;
    e_voice  = 0;
    e_flag   = 1'b0;
    e_st     = 1'b0;
    e_vi     = 0;
    e_start  = 1'b0;
    e_done   = 1'b0;
    e_ready  = 1'b1;
  endtask

  task automatic model_step();
    int  pre;
    bit  active;
    if (!i_reset_n) begin
      model_reset();
      return;
    end
    pre = exp_q.size();
    if (!running || fpos == CLKS - 1) begin
      running = i_enable;
      fpos    = 0;
    end else begin
      fpos++;
    end
    if (pend_pop) void'(exp_q.pop_front());
    if (i_note_valid && pre < DEPTH) exp_q.push_back({i_note_status, i_note_voice});
    if (i_note_valid && pre >= DEPTH) m_ovf = 1'b1;
    else if (i_clear_overflow) m_ovf = 1'b0;
    active  = running && fpos < 3 * NV;
    e_state = active ? fpos % 3 : 3;
    e_voice = fpos / 3;
    e_start = running && fpos == 0;
    e_done  = running && fpos == 3 * NV;
    e_flag  = active && (fpos % 3 == 0) && pre > 0;
    if (e_flag) begin
      e_st = exp_q[0][8];
      e_vi = int'(exp_q[0][7:0]);
    end
    pend_pop = e_flag;
    e_ready  = exp_q.size() < DEPTH;
  endtask

  task automatic check_outputs();
    check_eq("pipeline_state", 32'(o_pipeline_state), 32'(e_state));
    if (e_state != 3) check_eq("voice_index", 32'(o_voice_index), 32'(e_voice));
    check_eq("frame_start", 32'(o_frame_start), 32'(e_start));
    check_eq("frame_done", 32'(o_frame_done), 32'(e_done));
    check_eq("upd_flag", 32'(o_upd_flag), 32'(e_flag));
    check_eq("upd_note_status", 32'(o_upd_note_status), 32'(e_st));
    check_eq("upd_voice_index", 32'(o_upd_voice_index), 32'(e_vi));
    check_eq("note_ready", 32'(o_note_ready), 32'(e_ready));
    check_eq("overflow", 32'(o_overflow), 32'(m_ovf));
  endtask

  task automatic check_reset_values();
    check_eq("rst_state", 32'(o_pipeline_state), 32'd3);
    check_eq("rst_voice", 32'(o_voice_index), 32'd0);
    check_eq("rst_upd_flag", 32'(o_upd_flag), 32'd0);
    check_eq("rst_upd_status", 32'(o_upd_note_status), 32'd0);
    check_eq("rst_upd_voice", 32'(o_upd_voice_index), 32'd0);
    check_eq("rst_frame_start", 32'(o_frame_start), 32'd0);
    check_eq("rst_frame_done", 32'(o_frame_done), 32'd0);
    check_eq("rst_ready", 32'(o_note_ready), 32'd1);
    check_eq("rst_overflow", 32'(o_overflow), 32'd0);
  endtask

  int rst_hold;
  int burst;

  task automatic drive_inputs();
    if (!i_reset_n) begin
      if (rst_hold == 0) i_reset_n = 1'b1;
      else rst_hold--;
    end else if ($urandom_range(0, 399) == 0) begin
      i_reset_n = 1'b0;
      rst_hold  = $urandom_range(0, 2);
      #1;
      check_reset_values();
      model_reset();
    end
    if ($urandom_range(0, 24) == 0) i_enable = ~i_enable;
    if (burst == 0 && $urandom_range(0, 39) == 0) burst = 3;
    if (burst > 0) begin
      i_note_valid = 1'b1;
      burst--;
    end else begin
      i_note_valid = ($urandom_range(0, 3) == 0);
    end
    i_note_status    = 1'($urandom_range(0, 1));
    i_note_voice     = 8'($urandom_range(0, 255));
    i_clear_overflow = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    i_reset_n        = 1'b0;
    i_enable         = 1'b1;
    i_note_valid     = 1'b0;
    i_note_status    = 1'b0;
    i_note_voice     = 8'd0;
    i_clear_overflow = 1'b0;
    rst_hold         = 0;
    burst            = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    i_reset_n = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
      drive_inputs();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
